// File: rtl/seq_detector_1011_pkg.sv
// Shared types and constants for the 1011 serial pattern detector.
package seq_det_pkg;

  // Detector states. Each state name is the part of the pattern matched so far.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } state_e;

  // Pattern to detect. The MSB is the first bit received.
  localparam logic [3:0] PATTERN = 4'b1011;

  // Returns the bit that extends the partial match held in state s.
  function automatic logic expected_bit(state_e s);
    logic b;
    case (s)
      IDLE:    b = PATTERN[3];
      S1:      b = PATTERN[2];
      S10:     b = PATTERN[1];
      S101:    b = PATTERN[0];
      default: b = PATTERN[3];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/seq_detector_1011_if.sv
// Bundle between the upstream D flip-flop stage and the detector.
// The upstream register stage lives here, so q is d delayed by one clk.
interface seq_det_if #(
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst
);

  logic             d;
  logic             q;
  logic             bit_valid;
  logic             clear;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             busy;

  // Upstream D flip-flop stage feeding the detector's serial input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  // Producer side: drives the data and control, observes the results.
  modport master (
    output d,
    output bit_valid,
    output clear,
    input  q,
    input  match,
    input  match_count,
    input  busy
  );

  // Detector side: consumes the registered bit, drives the results.
  modport slave (
    input  q,
    input  bit_valid,
    input  clear,
    output match,
    output match_count,
    output busy
  );

endinterface

// File: rtl/seq_detector_1011_sat_counter.sv
// Counter that increments on inc and sticks at its maximum instead of wrapping.
// clr has priority over inc.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != COUNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_1011.sv
// Serial 1011 detector. Samples q when bit_valid is high, pulses match for one
// cycle after the final 1, and keeps a saturating count of matches.
// OVERLAP=1 lets the trailing 1 of a match start the next one.
module seq_detector_1011
  import seq_det_pkg::*;
#(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input logic      clk,
  input logic      rst,
  seq_det_if.slave bus
);

  state_e           state_q;
  state_e           state_d;
  logic             match_q;
  logic             match_d;
  logic [CNT_W-1:0] count;

  // Next state and match decision for the current sample.
  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    if (bus.clear) begin
      // A bit arriving together with clear is dropped.
      state_d = IDLE;
    end else if (bus.bit_valid) begin
      case (state_q)
        IDLE: state_d = (bus.q == expected_bit(IDLE)) ? S1   : IDLE;
        S1:   state_d = (bus.q == expected_bit(S1))   ? S10  : S1;
        S10:  state_d = (bus.q == expected_bit(S10))  ? S101 : IDLE;
        S101: begin
          if (bus.q == expected_bit(S101)) begin
            match_d = 1'b1;
            // The final 1 can be the first 1 of the next pattern.
            state_d = (OVERLAP != 0) ? S1 : IDLE;
          end else begin
            // "1010" still ends in "10".
            state_d = S10;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered match pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  // Counter steps on the same edge that raises match.
  sat_counter #(
    .WIDTH(CNT_W)
  ) u_match_count (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.clear),
    .inc  (match_d),
    .count(count)
  );

  assign bus.match       = match_q;
  assign bus.match_count = count;
  assign bus.busy        = (state_q != IDLE);

endmodule
